// File: rtl/avalon_mms_responder.sv
// avalon_mms_responder: on-chip RAM standing in for the SDRAM controller at
// the same Avalon-MM boundary. It reproduces the controller's visible timing:
// an init stall, periodic refresh stalls, a fixed read latency and a cap on
// outstanding reads.
module avalon_mms_responder #(
  parameter int P_MEM_NBIT   = 10,
  parameter int P_RD_LAT     = 3,
  parameter int P_MAX_PEND   = 2,
  parameter int P_INIT_NCYC  = 16,
  parameter int P_REF_PERIOD = 64,
  parameter int P_REF_NCYC   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [25:0] avalon_mms_address,
  input  logic [3:0]  avalon_mms_byteenable_n,
  input  logic        avalon_mms_chipselect,
  input  logic [31:0] avalon_mms_writedata,
  input  logic        avalon_mms_read_n,
  input  logic        avalon_mms_write_n,
  output logic [31:0] avalon_mms_readdata,
  output logic        avalon_mms_readdatavalid,
  output logic        avalon_mms_waitrequest,
  output logic        initdone,
  output logic        proto_err
);

  // One shared counter serves the init, active and refresh phases.
  localparam int CMAX = (P_INIT_NCYC > P_REF_PERIOD)
                      ? ((P_INIT_NCYC > P_REF_NCYC) ? P_INIT_NCYC : P_REF_NCYC)
                      : ((P_REF_PERIOD > P_REF_NCYC) ? P_REF_PERIOD : P_REF_NCYC);
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = $clog2(P_MAX_PEND + 1);

  localparam logic [CW-1:0] INIT_LAST = CW'(P_INIT_NCYC - 1);
  localparam logic [CW-1:0] ACT_LAST  = CW'(P_REF_PERIOD - 1);
  localparam logic [CW-1:0] REF_LAST  = CW'(P_REF_NCYC - 1);
  localparam logic [PW-1:0] PEND_FULL = PW'(P_MAX_PEND);

  typedef enum logic [1:0] {INIT, ACTIVE, REFRESH} state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic [PW-1:0]              pend;
  logic [P_RD_LAT:1]          vld_pipe;
  logic [P_RD_LAT:1][31:0]    dat_pipe;
  logic [31:0]                mem [0:(2**P_MEM_NBIT)-1];
  logic [P_MEM_NBIT-1:0]      addr;
  logic                       wr_acc, rd_acc, both_acc, rd_ret;
  logic                       unused;

  // Upper address bits alias onto the stored words.
  assign addr   = avalon_mms_address[P_MEM_NBIT-1:0];
  assign unused = ^avalon_mms_address[25:P_MEM_NBIT];

  // Stall decode depends only on registers, never on the command inputs.
  assign avalon_mms_waitrequest = (state != ACTIVE) || (pend == PEND_FULL);

  // A read issued together with a write is dropped; the write still lands.
  assign wr_acc   = avalon_mms_chipselect & ~avalon_mms_waitrequest & ~avalon_mms_write_n;
  assign rd_acc   = avalon_mms_chipselect & ~avalon_mms_waitrequest & ~avalon_mms_read_n
                    & avalon_mms_write_n;
  assign both_acc = avalon_mms_chipselect & ~avalon_mms_waitrequest & ~avalon_mms_read_n
                    & ~avalon_mms_write_n;

  // A read stops counting as pending when it enters the last pipe stage, so
  // P_MAX_PEND reads fit in P_RD_LAT cycles and MAX_PEND == RD_LAT never stalls.
  assign rd_ret = vld_pipe[P_RD_LAT-1];

  assign avalon_mms_readdata      = dat_pipe[P_RD_LAT];
  assign avalon_mms_readdatavalid = vld_pipe[P_RD_LAT];

  // State and phase counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      cnt      <= '0;
      initdone <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state_nxt != INIT) initdone <= 1'b1;
    end
  end

  // Next-state: init stall, then alternate active windows and refresh stalls.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      INIT:    if (cnt == INIT_LAST) begin state_nxt = ACTIVE;  cnt_nxt = '0; end
      ACTIVE:  if (cnt == ACT_LAST)  begin state_nxt = REFRESH; cnt_nxt = '0; end
      REFRESH: if (cnt == REF_LAST)  begin state_nxt = ACTIVE;  cnt_nxt = '0; end
      default: begin state_nxt = INIT; cnt_nxt = '0; end
    endcase
  end

  // Read pipeline, pending count and sticky protocol error; reset flushes reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      dat_pipe  <= '0;
      pend      <= '0;
      proto_err <= 1'b0;
    end else begin
      vld_pipe    <= {vld_pipe[P_RD_LAT-1:1], rd_acc};
      dat_pipe[1] <= mem[addr];
      for (int i = 2; i <= P_RD_LAT; i++) dat_pipe[i] <= dat_pipe[i-1];
      pend <= pend + PW'(rd_acc) - PW'(rd_ret);
      if (both_acc) proto_err <= 1'b1;
    end
  end

  // RAM write with per-byte enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc)
      for (int b = 0; b < 4; b++)
        if (!avalon_mms_byteenable_n[b]) mem[addr][8*b +: 8] <= avalon_mms_writedata[8*b +: 8];
  end

endmodule
